// File: rtl/feature_chunk_scheduler.sv
// ---------------------------------------------------------------------------
// feature_chunk_scheduler
//
// Arbitrates between two feature-frame requesters (for example the live mel
// frontend and a test/playback source) with round-robin fairness. It latches
// one whole frame at a time and streams it to the classifier as
// N_FEAT/CHUNK_W chunks under a valid/ready handshake. Each chunk carries its
// chunk index, its source and a last-chunk marker.
//
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-high reset
//   s0_valid/ready  requester 0 frame handshake
//   s0_data         requester 0 frame, coefficient k at [k*DATA_W +: DATA_W]
//   s1_valid/ready  requester 1 frame handshake
//   s1_data         requester 1 frame, same packing as s0_data
//   flush           synchronous abort of the frame in flight; in IDLE it
//                   blocks acceptance for that cycle
//   m_valid/ready   downstream chunk handshake
//   m_data          chunk; element j = frame coefficient m_idx*CHUNK_W+j
//   m_idx           chunk index within the frame
//   m_last          high on the final chunk of a frame
//   m_src           requester that supplied the frame being sent
//   busy            high while a frame is being sent
//   frame_cnt       frames fully delivered (wraps at 16 bits)
//
// CHUNK_W must divide N_FEAT exactly.
// ---------------------------------------------------------------------------
module feature_chunk_scheduler #(
   parameter  int N_FEAT  = 40,
   parameter  int CHUNK_W = 8,
   parameter  int DATA_W  = 16,
   localparam int N_CHUNK = N_FEAT / CHUNK_W,
   localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s0_valid,
   output logic                        s0_ready,
   input  logic [N_FEAT*DATA_W-1:0]    s0_data,
   input  logic                        s1_valid,
   output logic                        s1_ready,
   input  logic [N_FEAT*DATA_W-1:0]    s1_data,
   input  logic                        flush,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [CHUNK_W*DATA_W-1:0]   m_data,
   output logic [IDX_W-1:0]            m_idx,
   output logic                        m_last,
   output logic                        m_src,
   output logic                        busy,
   output logic [15:0]                 frame_cnt
);

   localparam int FRAME_BITS = N_FEAT * DATA_W;
   localparam int CHUNK_BITS = CHUNK_W * DATA_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                  state_q,      state_d;
   logic [IDX_W-1:0]        idx_q,        idx_d;
   logic                    src_q,        src_d;
   logic                    last_grant_q, last_grant_d;
   logic [15:0]             frame_cnt_q,  frame_cnt_d;
   logic [FRAME_BITS-1:0]   buf_q,        buf_d;

   logic                    grant_s;
   logic                    s0_ready_s;
   logic                    s1_ready_s;
   logic                    accept_s;

   // Next-state, arbitration and handshake decode.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      src_d        = src_q;
      last_grant_d = last_grant_q;
      frame_cnt_d  = frame_cnt_q;
      buf_d        = buf_q;
      s0_ready_s   = 1'b0;
      s1_ready_s   = 1'b0;
      accept_s     = 1'b0;

      // A lone valid requester wins outright; on a tie (or when nobody is
      // asking) the requester that was not served last has priority.
      if (s0_valid ^ s1_valid) begin
         grant_s = s1_valid;
      end else begin
         grant_s = ~last_grant_q;
      end

      case (state_q)
         ST_IDLE: begin
            s0_ready_s = (grant_s == 1'b0) && !flush;
            s1_ready_s = (grant_s == 1'b1) && !flush;
            accept_s   = (s0_ready_s && s0_valid) || (s1_ready_s && s1_valid);
            if (accept_s) begin
               if (grant_s) begin
                  buf_d = s1_data;
               end else begin
                  buf_d = s0_data;
               end
               src_d        = grant_s;
               last_grant_d = grant_s;
               idx_d        = '0;
               state_d      = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            // Flush wins even over a last-chunk handshake, so an aborted
            // frame is never counted as delivered.
            if (flush) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else if (m_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d     = ST_IDLE;
                  idx_d       = '0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State, index, source, fairness pointer, counter and frame buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         src_q        <= 1'b0;
         last_grant_q <= 1'b1;
         frame_cnt_q  <= 16'd0;
         buf_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         src_q        <= src_d;
         last_grant_q <= last_grant_d;
         frame_cnt_q  <= frame_cnt_d;
         buf_q        <= buf_d;
      end
   end

   assign s0_ready  = s0_ready_s;
   assign s1_ready  = s1_ready_s;
   assign m_valid   = (state_q == ST_SEND);
   assign busy      = (state_q == ST_SEND);
   assign m_idx     = idx_q;
   assign m_src     = src_q;
   assign m_last    = (state_q == ST_SEND) && (idx_q == LAST_IDX);
   assign frame_cnt = frame_cnt_q;
   // idx_q never exceeds LAST_IDX, so the slice stays inside the buffer.
   assign m_data    = buf_q[idx_q * CHUNK_BITS +: CHUNK_BITS];

endmodule

// File: tb/tb_feature_chunk_scheduler.sv
// ---------------------------------------------------------------------------
// tb_feature_chunk_scheduler
//
// Directed bench for feature_chunk_scheduler with the default parameters
// (40 coefficients, 8 per chunk, 16-bit, 5 chunks per frame). Inputs change
// 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_feature_chunk_scheduler;

   localparam int FB = 640;
   localparam int CB = 128;

   logic            clk = 1'b0;
   logic            reset;
   logic            s0_valid, s1_valid;
   logic            s0_ready, s1_ready;
   logic [FB-1:0]   s0_data, s1_data;
   logic            flush;
   logic            m_valid, m_ready;
   logic [CB-1:0]   m_data;
   logic [2:0]      m_idx;
   logic            m_last, m_src, busy;
   logic [15:0]     frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   feature_chunk_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .s0_valid  (s0_valid),
      .s0_ready  (s0_ready),
      .s0_data   (s0_data),
      .s1_valid  (s1_valid),
      .s1_ready  (s1_ready),
      .s1_data   (s1_data),
      .flush     (flush),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_idx     (m_idx),
      .m_last    (m_last),
      .m_src     (m_src),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   // Frame whose coefficient k equals base+k.
   function automatic logic [FB-1:0] make_frame(input logic [15:0] base);
      logic [FB-1:0] f;
      for (int k = 0; k < 40; k++) f[k*16 +: 16] = base + 16'(k);
      return f;
   endfunction

   // Expected chunk idx of a make_frame(base) frame.
   function automatic logic [CB-1:0] exp_chunk(input logic [15:0] base, input int idx);
      logic [CB-1:0] c;
      for (int j = 0; j < 8; j++) c[j*16 +: 16] = base + 16'(idx*8 + j);
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
      s0_data = '0; s1_data = '0;
      s0_valid = 1'b1; s1_valid = 1'b1;
      #3;
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %0b exp 0", m_valid); end
      n_vec++; if (m_idx !== 3'd0) begin n_err++; $display("FAIL rst_m_idx got %0d exp 0", m_idx); end
      n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last got %0b exp 0", m_last); end
      n_vec++; if (m_src !== 1'b0) begin n_err++; $display("FAIL rst_m_src got %0b exp 0", m_src); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b exp 0", busy); end
      n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
      n_vec++; if (s0_ready !== 1'b1) begin n_err++; $display("FAIL rst_s0_prio got %0b exp 1", s0_ready); end
      n_vec++; if (s1_ready !== 1'b0) begin n_err++; $display("FAIL rst_s1_prio got %0b exp 0", s1_ready); end
      s0_valid = 1'b0; s1_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_frame();
      s0_data = make_frame(16'h0100); s0_valid = 1'b1; m_ready = 1'b1;
      #1;
      n_vec++; if (s0_ready !== 1'b1) begin n_err++; $display("FAIL single_s0_ready got %0b exp 1", s0_ready); end
      step();
      s0_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d] got %0b exp 1", i, m_valid); end
         n_vec++; if (m_idx !== 3'(i)) begin n_err++; $display("FAIL single_idx[%0d] got %0d exp %0d", i, m_idx, i); end
         n_vec++; if (m_data !== exp_chunk(16'h0100, i)) begin n_err++; $display("FAIL single_data[%0d] got %h exp %h", i, m_data, exp_chunk(16'h0100, i)); end
         n_vec++; if (m_last !== (i == 4)) begin n_err++; $display("FAIL single_last[%0d] got %0b", i, m_last); end
         n_vec++; if (m_src !== 1'b0) begin n_err++; $display("FAIL single_src[%0d] got %0b exp 0", i, m_src); end
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy[%0d] got %0b exp 1", i, busy); end
         n_vec++; if (s0_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_send[%0d] got %0b exp 0", i, s0_ready); end
         if (i == 2) begin
            n_vec++; if (m_data[15:0] !== 16'h0110) begin n_err++; $display("FAIL single_c2_lo got %h exp 0110", m_data[15:0]); end
            n_vec++; if (m_data[127:112] !== 16'h0117) begin n_err++; $display("FAIL single_c2_hi got %h exp 0117", m_data[127:112]); end
         end
         step();
      end
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_end_valid got %0b exp 0", m_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_end_busy got %0b exp 0", busy); end
      n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL single_frame_cnt got %0d exp 1", frame_cnt); end
   endtask

   task automatic test_round_robin();
      logic [15:0] base;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      s0_data = make_frame(16'h1000); s1_data = make_frame(16'h2000);
      s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
      #1;
      for (int f = 0; f < 4; f++) begin
         base = (f % 2 == 0) ? 16'h1000 : 16'h2000;
         n_vec++; if (s0_ready !== (f % 2 == 0)) begin n_err++; $display("FAIL rr_s0_ready[f%0d] got %0b", f, s0_ready); end
         n_vec++; if (s1_ready !== (f % 2 == 1)) begin n_err++; $display("FAIL rr_s1_ready[f%0d] got %0b", f, s1_ready); end
         step();
         for (int i = 0; i < 5; i++) begin
            n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[f%0d,%0d] got %0b exp 1", f, i, m_valid); end
            n_vec++; if (m_src !== 1'(f % 2)) begin n_err++; $display("FAIL rr_src[f%0d,%0d] got %0b exp %0d", f, i, m_src, f % 2); end
            n_vec++; if (m_idx !== 3'(i)) begin n_err++; $display("FAIL rr_idx[f%0d] got %0d exp %0d", f, m_idx, i); end
            n_vec++; if (m_data !== exp_chunk(base, i)) begin n_err++; $display("FAIL rr_data[f%0d,%0d] got %h exp %h", f, i, m_data, exp_chunk(base, i)); end
            n_vec++; if ((s0_ready | s1_ready) !== 1'b0) begin n_err++; $display("FAIL rr_ready_send[f%0d,%0d] got %0b%0b exp 00", f, i, s0_ready, s1_ready); end
            step();
         end
      end
      s0_valid = 1'b0; s1_valid = 1'b0;
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rr_end_valid got %0b exp 0", m_valid); end
      n_vec++; if (frame_cnt !== 16'd4) begin n_err++; $display("FAIL rr_frame_cnt got %0d exp 4", frame_cnt); end
   endtask

   task automatic test_backpressure();
      int exp_idx = 0;
      int hs = 0;
      int cyc = 0;
      s1_data = make_frame(16'h3000); s1_valid = 1'b1; m_ready = 1'b0;
      #1;
      n_vec++; if (s1_ready !== 1'b1) begin n_err++; $display("FAIL bp_s1_ready got %0b exp 1", s1_ready); end
      step();
      s1_valid = 1'b0;
      while (m_valid === 1'b1 && cyc < 40) begin
         n_vec++; if (m_idx !== 3'(exp_idx)) begin n_err++; $display("FAIL bp_idx[c%0d] got %0d exp %0d", cyc, m_idx, exp_idx); end
         n_vec++; if (m_data !== exp_chunk(16'h3000, exp_idx)) begin n_err++; $display("FAIL bp_data[c%0d] got %h exp %h", cyc, m_data, exp_chunk(16'h3000, exp_idx)); end
         n_vec++; if (m_last !== (exp_idx == 4)) begin n_err++; $display("FAIL bp_last[c%0d] got %0b", cyc, m_last); end
         n_vec++; if (m_src !== 1'b1) begin n_err++; $display("FAIL bp_src[c%0d] got %0b exp 1", cyc, m_src); end
         m_ready = (cyc % 3 == 0);
         if (m_ready) begin hs++; exp_idx++; end
         step();
         cyc++;
      end
      m_ready = 1'b1;
      n_vec++; if (hs !== 5) begin n_err++; $display("FAIL bp_handshakes got %0d exp 5", hs); end
      n_vec++; if (cyc !== 13) begin n_err++; $display("FAIL bp_cycles got %0d exp 13", cyc); end
      n_vec++; if (frame_cnt !== 16'd5) begin n_err++; $display("FAIL bp_frame_cnt got %0d exp 5", frame_cnt); end
   endtask

   task automatic test_flush();
      s0_data = make_frame(16'h4000); s0_valid = 1'b1; m_ready = 1'b1;
      #1;
      n_vec++; if (s0_ready !== 1'b1) begin n_err++; $display("FAIL fl_s0_ready got %0b exp 1", s0_ready); end
      step();
      s0_valid = 1'b0;
      step(); step();
      n_vec++; if (m_idx !== 3'd2) begin n_err++; $display("FAIL fl_idx2 got %0d exp 2", m_idx); end
      flush = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1; s1_data = make_frame(16'h5000);
      step();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %0b exp 0", m_valid); end
      n_vec++; if (m_idx !== 3'd0) begin n_err++; $display("FAIL fl_idx got %0d exp 0", m_idx); end
      n_vec++; if (frame_cnt !== 16'd5) begin n_err++; $display("FAIL fl_frame_cnt got %0d exp 5", frame_cnt); end
      n_vec++; if ((s0_ready | s1_ready) !== 1'b0) begin n_err++; $display("FAIL fl_idle_block got %0b%0b exp 00", s0_ready, s1_ready); end
      step();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fl_blocked_valid got %0b exp 0", m_valid); end
      flush = 1'b0;
      #1;
      n_vec++; if (s1_ready !== 1'b1) begin n_err++; $display("FAIL fl_regrant_s1 got %0b exp 1", s1_ready); end
      n_vec++; if (s0_ready !== 1'b0) begin n_err++; $display("FAIL fl_regrant_s0 got %0b exp 0", s0_ready); end
      step();
      s0_valid = 1'b0; s1_valid = 1'b0;
      n_vec++; if (m_src !== 1'b1) begin n_err++; $display("FAIL fl_next_src got %0b exp 1", m_src); end
      n_vec++; if (m_data !== exp_chunk(16'h5000, 0)) begin n_err++; $display("FAIL fl_next_data got %h exp %h", m_data, exp_chunk(16'h5000, 0)); end
      repeat (5) step();
      n_vec++; if (frame_cnt !== 16'd6) begin n_err++; $display("FAIL fl_next_cnt got %0d exp 6", frame_cnt); end
      // Flush coinciding with the last-chunk handshake.
      s0_valid = 1'b1;
      step();
      s0_valid = 1'b0;
      repeat (4) step();
      n_vec++; if (m_last !== 1'b1) begin n_err++; $display("FAIL fl_last_pre got %0b exp 1", m_last); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fl_last_valid got %0b exp 0", m_valid); end
      n_vec++; if (frame_cnt !== 16'd6) begin n_err++; $display("FAIL fl_last_cnt got %0d exp 6", frame_cnt); end
   endtask

   task automatic test_async_reset();
      s0_data = make_frame(16'h4000); s0_valid = 1'b1; m_ready = 1'b1;
      step();
      s0_valid = 1'b0;
      repeat (3) step();
      n_vec++; if (m_idx !== 3'd3) begin n_err++; $display("FAIL ar_pre_idx got %0d exp 3", m_idx); end
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %0b exp 0", m_valid); end
      n_vec++; if (m_idx !== 3'd0) begin n_err++; $display("FAIL ar_idx got %0d exp 0", m_idx); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %0b exp 0", busy); end
      n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL ar_frame_cnt got %0d exp 0", frame_cnt); end
      n_vec++; if (m_src !== 1'b0) begin n_err++; $display("FAIL ar_src got %0b exp 0", m_src); end
      #1;
      reset = 1'b0;
      s1_data = make_frame(16'h6000); s1_valid = 1'b1;
      #1;
      n_vec++; if (s1_ready !== 1'b1) begin n_err++; $display("FAIL ar_s1_ready got %0b exp 1", s1_ready); end
      step();
      s1_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_vec++; if (m_idx !== 3'(i)) begin n_err++; $display("FAIL ar_idx[%0d] got %0d exp %0d", i, m_idx, i); end
         n_vec++; if (m_data !== exp_chunk(16'h6000, i)) begin n_err++; $display("FAIL ar_data[%0d] got %h exp %h", i, m_data, exp_chunk(16'h6000, i)); end
         n_vec++; if (m_src !== 1'b1) begin n_err++; $display("FAIL ar_src[%0d] got %0b exp 1", i, m_src); end
         step();
      end
      n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL ar_frame_cnt_after got %0d exp 1", frame_cnt); end
   endtask

   task automatic test_wrap();
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      #1;
      n_vec++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %h exp ffff", frame_cnt); end
      s0_data = make_frame(16'h7000); s0_valid = 1'b1; m_ready = 1'b1;
      step();
      s0_valid = 1'b0;
      repeat (4) step();
      n_vec++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_mid got %h exp ffff", frame_cnt); end
      step();
      n_vec++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt got %h exp 0000", frame_cnt); end
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid got %0b exp 0", m_valid); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/feature_chunk_scheduler.md
Name: feature_chunk_scheduler

Overview:
- Schedules and arbitrates the shared chunked feature path feeding the classifier.
- Two requesters each offer a full N_FEAT-coefficient feature frame (e.g. live mel frontend and test/playback source); the block grants one frame at a time with round-robin fairness.
- It latches the granted frame and emits it downstream as N_FEAT/CHUNK_W chunks of CHUNK_W coefficients under valid/ready, tagging chunk index, source and last-chunk.
- It sits between the mel/feature stage and the classifier input.

Parameters:
- N_FEAT, 40: coefficients per frame.
- CHUNK_W, 8: coefficients per output chunk. Must divide N_FEAT exactly; N_CHUNK = N_FEAT/CHUNK_W.
- DATA_W, 16: bits per coefficient.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s0_valid  in  1  requester 0 frame valid
- s0_ready  out  1  requester 0 frame accepted
- s0_data  in  N_FEAT*DATA_W  requester 0 frame; coefficient k at bits [k*DATA_W +: DATA_W]
- s1_valid  in  1  requester 1 frame valid
- s1_ready  out  1  requester 1 frame accepted
- s1_data  in  N_FEAT*DATA_W  requester 1 frame, same packing as s0_data
- flush  in  1  synchronous abort of the frame in flight
- m_valid  out  1  chunk valid
- m_ready  in  1  downstream ready
- m_data  out  CHUNK_W*DATA_W  chunk; element j = frame coefficient idx*CHUNK_W+j
- m_idx  out  $clog2(N_CHUNK) (min 1)  chunk index of m_data
- m_last  out  1  high when m_idx == N_CHUNK-1 and m_valid
- m_src  out  1  source of the current frame (0/1)
- busy  out  1  high in SEND state
- frame_cnt  out  16  frames fully delivered; wraps 0xFFFF->0

Behaviour:
- Clock and reset: clk, posedge-triggered; reset, asynchronous, active-high.
- Reset values:
  - State IDLE; m_valid=0; m_idx=0; m_last=0; m_src=0; busy=0.
  - frame_cnt=0; frame buffer all zero.
  - last_grant=1, so requester 0 has first priority.
- States: IDLE and SEND.
- IDLE:
  - Grant is combinational from s0_valid, s1_valid and last_grant.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
  - sX_ready = (state==IDLE) && (grant==X) && !flush. At most one ready is high; neither is high outside IDLE.
  - On handshake: latch sX_data into the buffer, set m_src=X and last_grant=X, set idx=0, go to SEND.
- SEND:
  - m_valid=1 and busy=1. m_data, m_idx and m_src are driven from registers and the buffer.
  - While m_valid && !m_ready, all outputs hold stable.
  - On m_valid && m_ready with idx < N_CHUNK-1: idx increments.
  - On m_valid && m_ready with idx == N_CHUNK-1: go to IDLE, idx=0, frame_cnt+1.
- Latency and throughput:
  - Frame handshake at edge T gives first chunk valid in the cycle after T.
  - With m_ready held high, the frame takes N_CHUNK cycles of m_valid and then at least 1 IDLE cycle. Throughput is 1 frame per N_CHUNK+1 cycles.
- flush:
  - In SEND, flush forces IDLE at the next edge: m_valid=0 the next cycle, idx=0, frame_cnt unchanged. This holds even if it coincides with a last-chunk handshake; that frame is not counted.
  - last_grant keeps the flushed source, so the other source gets priority.
  - In IDLE, flush blocks acceptance for that cycle.
- Inputs are not required to be held: an unaccepted requester may drop valid without effect.
- Reset mid-frame: the frame is discarded immediately and the block returns to the reset values above.
- Buffer is only written on an accepted handshake. Its content persists in IDLE but is not observable there, since m_valid=0.

Test Plan:
- Single frame, s0 only, coeff k = 16'h0100+k, m_ready=1 → 5 chunks on consecutive cycles; chunk 2 = coeffs 16..23 (16'h0110..16'h0117); m_last only on idx 4; m_src=0; frame_cnt=1.
- s0 and s1 valid continuously from reset → grants alternate 0,1,0,1; each s_ready pulses for exactly 1 cycle; after 4 frames frame_cnt=4.
- Backpressure: m_ready toggles 1,0,0,1,… during a frame → m_data/m_idx stable while stalled; no chunk skipped or duplicated; exactly 5 handshakes.
- Flush asserted on the idx=2 handshake cycle → m_valid=0 the next cycle; frame_cnt unchanged; with both requesters valid, the next grant goes to the other source.
- Async reset asserted mid-SEND (idx=3) → outputs go to reset values without waiting for a clock edge; after release, s1-only valid is granted and delivered from idx 0.
- frame_cnt preloaded by running 65535 frames (or forced) → the next completed frame wraps it to 0.
